// File: rtl/quantization_if.sv
// Handshake/data bundle for the quantization block.
// QUANT_SAT_FLAG_EN adds the sat_flag signal.
interface quantization_if #(
    parameter int unsigned MAXBITWIDTH = 16
);
    localparam int unsigned BW = $clog2(MAXBITWIDTH) + 1;

    logic                   values_rdy;
    logic [BW-1:0]          bitwidth;
    logic [31:0]            value;
    logic [31:0]            scale_inv_fp;
    logic                   rdy;
    logic                   next_module_rdy;
    logic                   result_rdy;
    logic [MAXBITWIDTH-1:0] result;
`ifdef QUANT_SAT_FLAG_EN
    logic                   sat_flag;

    modport master (
        output values_rdy, bitwidth, value, scale_inv_fp, next_module_rdy,
        input  rdy, result_rdy, result, sat_flag
    );
    modport slave (
        input  values_rdy, bitwidth, value, scale_inv_fp, next_module_rdy,
        output rdy, result_rdy, result, sat_flag
    );
`else
    modport master (
        output values_rdy, bitwidth, value, scale_inv_fp, next_module_rdy,
        input  rdy, result_rdy, result
    );
    modport slave (
        input  values_rdy, bitwidth, value, scale_inv_fp, next_module_rdy,
        output rdy, result_rdy, result
    );
`endif
endinterface

// File: rtl/quantization.sv
// fp32 -> signed integer quantizer: q = sat_b(RNE(value * scale_inv_fp)), multi-cycle.
// Optional QUANT_SAT_FLAG_EN adds a sat_flag output reporting clamping.
module quantization #(
    parameter int unsigned MAXBITWIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    quantization_if.slave bus
);
    localparam int unsigned BW = $clog2(MAXBITWIDTH) + 1;
    localparam int unsigned MW = MAXBITWIDTH;
    localparam logic signed [10:0] MW_S = 11'(MAXBITWIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_SAT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                rdy_q;
    logic                result_rdy_q;
    logic [MW-1:0]       result_q;
    logic [31:0]         a_q, b_q;
    logic [BW-1:0]       bw_q;
    logic                sign_q, zero_q, inf_q;
    logic signed [10:0]  exp_q;
    logic [47:0]         mcand_q, acc_q;
    logic [23:0]         mplier_q;
    logic [4:0]          cnt_q;
    logic [MW:0]         mag_q;
    logic                guard_q, sticky_q, fsat_q;
`ifdef QUANT_SAT_FLAG_EN
    logic                sat_q;
`endif

    // Operand classification
    logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    always_comb begin
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
        b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
        a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
        b_inf  = (&b_q[30:23]) && !(|b_q[22:0]);
    end

    // Normalise: integer part of P * 2^(E-46) plus guard/sticky
    logic signed [10:0] shamt;
    logic [MW:0]        norm_mag;
    logic               norm_g, norm_s, norm_fsat;
    always_comb begin
        shamt     = 11'sd46 - exp_q;
        norm_mag  = '0;
        norm_g    = 1'b0;
        norm_s    = 1'b0;
        norm_fsat = !zero_q && (inf_q || (exp_q >= MW_S));
        if (zero_q || norm_fsat) begin
            norm_mag = '0;
        end else if (shamt > 11'sd48) begin
            // |x| < 0.5 and nonzero: rounds to zero
            norm_s = 1'b1;
        end else begin
            norm_mag = (MW+1)'(acc_q >> shamt[5:0]);
            norm_g   = |((acc_q >> (shamt[5:0] - 6'd1)) & 48'd1);
            norm_s   = |(acc_q << (6'd49 - shamt[5:0]));
        end
    end

    // Saturate to the effective bitwidth and apply sign
    logic [BW-1:0] beff;
    logic [MW:0]   lim_pos, lim_neg, mag_c;
    logic          sat_c;
    logic [MW-1:0] res_c;
    always_comb begin
        beff = bw_q;
        if (bw_q < BW'(2)) begin
            beff = BW'(2);
        end else if (bw_q > BW'(MW)) begin
            beff = BW'(MW);
        end
        lim_neg = (MW+1)'(1) << (beff - BW'(1));
        lim_pos = lim_neg - (MW+1)'(1);
        sat_c   = fsat_q || (sign_q ? (mag_q > lim_neg) : (mag_q > lim_pos));
        mag_c   = mag_q;
        if (sat_c) begin
            mag_c = sign_q ? lim_neg : lim_pos;
        end
        res_c = MW'(sign_q ? (~mag_c + (MW+1)'(1)) : mag_c);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.values_rdy) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MUL;
            S_MUL:    if (cnt_q == 5'd23) state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_SAT;
            S_SAT:    state_d = S_DONE;
            S_DONE:   if (result_rdy_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b0;
            result_rdy_q <= 1'b0;
            result_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            bw_q         <= '0;
            sign_q       <= 1'b0;
            zero_q       <= 1'b0;
            inf_q        <= 1'b0;
            exp_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mag_q        <= '0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            fsat_q       <= 1'b0;
`ifdef QUANT_SAT_FLAG_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (bus.values_rdy) begin
                        a_q  <= bus.value;
                        b_q  <= bus.scale_inv_fp;
                        bw_q <= bus.bitwidth;
                    end
                end
                S_UNPACK: begin
                    sign_q   <= a_q[31] ^ b_q[31];
                    exp_q    <= $signed({3'b000, a_q[30:23]}) + $signed({3'b000, b_q[30:23]}) - 11'sd254;
                    mcand_q  <= {24'h000000, 1'b1, a_q[22:0]};
                    mplier_q <= {1'b1, b_q[22:0]};
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    // NaN and zero/denormal (including 0*Inf) outrank Inf
                    zero_q   <= a_nan | b_nan | a_zero | b_zero;
                    inf_q    <= a_inf | b_inf;
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                end
                S_NORM: begin
                    mag_q    <= norm_mag;
                    guard_q  <= norm_g;
                    sticky_q <= norm_s;
                    fsat_q   <= norm_fsat;
                end
                S_ROUND: begin
                    if (guard_q && (sticky_q || mag_q[0])) mag_q <= mag_q + (MW+1)'(1);
                end
                S_SAT: begin
                    result_q <= res_c;
`ifdef QUANT_SAT_FLAG_EN
                    sat_q    <= sat_c;
`endif
                end
                S_DONE: begin
                    // pulse one cycle after downstream is ready, then leave
                    result_rdy_q <= !result_rdy_q && bus.next_module_rdy;
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy        = rdy_q;
    assign bus.result_rdy = result_rdy_q;
    assign bus.result     = result_q;
`ifdef QUANT_SAT_FLAG_EN
    assign bus.sat_flag   = sat_q;
`endif
endmodule

// File: tb/tb_quantization.sv
// Self-checking bench for quantization: vector table + scoreboard, plus stall and reset sequences.
module tb_quantization;
    localparam int unsigned MW = 16;
    localparam int NV = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quantization_if #(.MAXBITWIDTH(MW)) bus ();
    quantization #(.MAXBITWIDTH(MW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] v;
        logic [31:0] s;
        logic [4:0]  b;
        logic [15:0] r;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [15:0] r;
        logic        sat;
        int          idx;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (bus.result_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_rdy: got result_rdy=1 result=0x%0h, expected no result", bus.result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_%0d", e.idx), 32'(bus.result), 32'(e.r));
`ifdef QUANT_SAT_FLAG_EN
                check($sformatf("sat_flag_%0d", e.idx), 32'(bus.sat_flag), 32'(e.sat));
`endif
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [31:0] s, input logic [4:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got rdy=%b, expected 1 within 100 cycles", bus.rdy);
        end
        bus.value        = v;
        bus.scale_inv_fp = s;
        bus.bitwidth     = b;
        bus.values_rdy   = 1'b1;
        @(posedge clk);
        #1;
        bus.values_rdy   = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus.result_rdy !== 1'b1 && cyc < budget);
        if (bus.result_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no result_rdy, expected one within %0d cycles", budget);
            sb.delete();
        end
    endtask

    task automatic push(input logic [15:0] r, input logic sat, input int idx);
        exp_t x;
        x.r = r; x.sat = sat; x.idx = idx;
        sb.push_back(x);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic stall_rdy_bad, stall_res_bad, stall_busy_bad;

        vecs[0]  = '{32'h40200000, 32'h3F800000, 5'd8,  16'h0002, 1'b0};
        vecs[1]  = '{32'hC0600000, 32'h3F800000, 5'd8,  16'hFFFC, 1'b0};
        vecs[2]  = '{32'h42C80000, 32'h40000000, 5'd8,  16'h007F, 1'b1};
        vecs[3]  = '{32'hC2C80000, 32'h40000000, 5'd4,  16'hFFF8, 1'b1};
        vecs[4]  = '{32'h7F800000, 32'h3F800000, 5'd16, 16'h7FFF, 1'b1};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 5'd16, 16'h0000, 1'b0};
        vecs[6]  = '{32'h00000001, 32'h3F800000, 5'd16, 16'h0000, 1'b0};
        vecs[7]  = '{32'h3F000000, 32'h3F800000, 5'd8,  16'h0000, 1'b0};
        vecs[8]  = '{32'h3FC00000, 32'h3F800000, 5'd8,  16'h0002, 1'b0};
        vecs[9]  = '{32'hBE800000, 32'h3F800000, 5'd8,  16'h0000, 1'b0};
        vecs[10] = '{32'hFF800000, 32'h3F800000, 5'd16, 16'h8000, 1'b1};
        vecs[11] = '{32'h00000000, 32'h7F800000, 5'd16, 16'h0000, 1'b0};
        vecs[12] = '{32'h40A00000, 32'h3F800000, 5'd1,  16'h0001, 1'b1};
        vecs[13] = '{32'h447A0000, 32'h3F800000, 5'd31, 16'h03E8, 1'b0};
        vecs[14] = '{32'hC3000000, 32'h3F800000, 5'd8,  16'hFF80, 1'b0};
        vecs[15] = '{32'h3F400000, 32'h3F400000, 5'd8,  16'h0001, 1'b0};
        vecs[16] = '{32'h3FC00000, 32'h3FC00000, 5'd8,  16'h0002, 1'b0};
        vecs[17] = '{32'h40F00000, 32'h3F800000, 5'd4,  16'h0007, 1'b1};
        vecs[18] = '{32'h47800000, 32'h3F800000, 5'd16, 16'h7FFF, 1'b1};
        vecs[19] = '{32'h46FFFF00, 32'h3F800000, 5'd16, 16'h7FFF, 1'b1};
        vecs[20] = '{32'h40400000, 32'h3F800000, 5'd8,  16'h0003, 1'b0};

        bus.values_rdy      = 1'b0;
        bus.value           = '0;
        bus.scale_inv_fp    = '0;
        bus.bitwidth        = '0;
        bus.next_module_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 32'(bus.rdy), 32'd0);
        check("reset_result_rdy", 32'(bus.result_rdy), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_reset", 32'(bus.rdy), 32'd1);

        for (int i = 0; i < NV; i++) begin
            push(vecs[i].r, vecs[i].sat, i);
            send(vecs[i].v, vecs[i].s, vecs[i].b);
            if (i == 0) check("rdy_drop", 32'(bus.rdy), 32'd0);
            wait_result(60, cyc);
            if (i == 0) begin
                check("latency", 32'(cyc), 32'd29);
                @(posedge clk);
                #1;
                check("pulse_width", 32'(bus.result_rdy), 32'd0);
                check("rdy_after_pulse", 32'(bus.rdy), 32'd1);
            end
        end

        // Downstream stall at DONE
        bus.next_module_rdy = 1'b0;
        push(16'hFFFC, 1'b0, 100);
        send(32'hC0600000, 32'h3F800000, 5'd8);
        repeat (28) @(posedge clk);
        stall_rdy_bad = 1'b0; stall_res_bad = 1'b0; stall_busy_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.result_rdy !== 1'b0) stall_rdy_bad = 1'b1;
            if (bus.result !== 16'hFFFC) stall_res_bad = 1'b1;
            if (bus.rdy !== 1'b0) stall_busy_bad = 1'b1;
        end
        check("stall_result_rdy_low", 32'(stall_rdy_bad), 32'd0);
        check("stall_result_stable", 32'(stall_res_bad), 32'd0);
        check("stall_rdy_low", 32'(stall_busy_bad), 32'd0);
        @(negedge clk);
        bus.next_module_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_pulse", 32'(bus.result_rdy), 32'd1);
        check("stall_release_rdy", 32'(bus.rdy), 32'd0);
        @(posedge clk);
        #1;
        check("stall_pulse_single", 32'(bus.result_rdy), 32'd0);
        check("stall_rdy_return", 32'(bus.rdy), 32'd1);

        // Reset during MUL discards the transaction
        send(32'h42C80000, 32'h40000000, 5'd8);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy_low", 32'(bus.rdy), 32'd0);
        check("midrst_result_clear", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rdy_high", 32'(bus.rdy), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("midrst_result_held", 32'(bus.result), 32'd0);
        push(16'h0003, 1'b0, 200);
        send(32'h40400000, 32'h3F800000, 5'd8);
        wait_result(60, cyc);
        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
